// File: rtl/line_mem_controller_pkg.sv
// line_mem_controller_pkg
//   Shared types and constants for the cache-line transfer responder.
//   - LMCState_t : controller FSM states
//   - LMCReq_t   : request latched at acceptance {we, sramAddr, extAddr, id}
//   - LMC_SRAM_AW / LMC_EXT_AW / LMC_DATA_W : address and data widths
//   - lmc_word_addr() : SRAM word address of word idx inside a line (wraps mod 2^10)
package line_mem_controller_pkg;

  localparam int LMC_SRAM_AW  = 10;
  localparam int LMC_EXT_AW   = 30;
  localparam int LMC_DATA_W   = 32;
  // Widest cache ID the latched request can carry; the top truncates to its own ID width.
  localparam int LMC_ID_MAX_W = 8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CMD     = 2'd1,
    XFER_RD = 2'd2,
    XFER_WR = 2'd3
  } LMCState_t;

  typedef struct packed {
    logic                    we;
    logic [LMC_SRAM_AW-1:0]  sramAddr;
    logic [LMC_EXT_AW-1:0]   extAddr;
    logic [LMC_ID_MAX_W-1:0] id;
  } LMCReq_t;

  function automatic logic [LMC_SRAM_AW-1:0] lmc_word_addr(
    input logic [LMC_SRAM_AW-1:0] base,
    input logic [LMC_SRAM_AW-1:0] idx
  );
    return base + idx;
  endfunction

endpackage

// File: rtl/line_mem_controller_skid_fifo.sv
// lmc_skid_fifo
//   Two-entry 32-bit FIFO buffering SRAM read data in front of the external
//   write-data channel. Push is ignored when full, pop when empty.
// Ports:
//   clk, rst (async, active-low)
//   push / push_data : enqueue one word
//   pop              : dequeue the head word
//   head             : current head word (valid when !empty)
//   empty / full     : occupancy flags
module lmc_skid_fifo
  import line_mem_controller_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [LMC_DATA_W-1:0] push_data,
  input  logic                  pop,
  output logic [LMC_DATA_W-1:0] head,
  output logic                  empty,
  output logic                  full
);

  logic [LMC_DATA_W-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;
  logic [1:0]            count;
  logic                  do_push;
  logic                  do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  // Storage needs no reset: count gates visibility of every entry.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  assign head  = mem[rd_ptr];
  assign empty = (count == 2'd0);
  assign full  = (count == 2'd2);

endmodule

// File: rtl/line_mem_controller.sv
// line_mem_controller
//   Responder that accepts single-cycle line requests from NUM_CACHES cache
//   controllers and moves one LINE_WORDS-word line between external memory
//   and the cache SRAM (load: ext -> SRAM, evict: SRAM -> ext).
//   Build option: define LMC_RR_ARB_EN for round-robin arbitration; otherwise
//   fixed priority with the lowest requesting index winning.
// Ports:
//   clk, rst (async, active-low)
//   IN_ce/IN_we/IN_sramAddr/IN_extAddr : per-cache request (ce is a 1-cycle strobe)
//   OUT_busy, OUT_cacheID, OUT_progress : transfer status for the requesters
//   OUT_CACHE_ce/we/addr/data, IN_CACHE_data : SRAM port (read data 1 cycle after strobe)
//   OUT_EXT_cmdValid/IN_EXT_cmdReady/OUT_EXT_write/OUT_EXT_addr : ext command
//   OUT_EXT_wValid/OUT_EXT_wData/IN_EXT_wReady : ext write data
//   IN_EXT_rValid/IN_EXT_rData : ext read data (no backpressure)
//   OUT_dbgState : current FSM state
// Handshake: a transfer on a valid/ready channel happens on a rising clk edge
//   where valid and ready are both 1; once valid rises, payload is held stable
//   and valid stays 1 until that edge. rValid has no ready and is taken as-is.
module line_mem_controller
  import line_mem_controller_pkg::*;
#(
  parameter int  NUM_CACHES = 2,
  parameter int  LINE_WORDS = 64,
  localparam int ID_W       = (NUM_CACHES > 1) ? $clog2(NUM_CACHES) : 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [NUM_CACHES-1:0]                  IN_ce,
  input  logic [NUM_CACHES-1:0]                  IN_we,
  input  logic [NUM_CACHES-1:0][LMC_SRAM_AW-1:0] IN_sramAddr,
  input  logic [NUM_CACHES-1:0][LMC_EXT_AW-1:0]  IN_extAddr,
  output logic                                   OUT_busy,
  output logic [ID_W-1:0]                        OUT_cacheID,
  output logic [LMC_SRAM_AW-1:0]                 OUT_progress,
  output logic                                   OUT_CACHE_ce,
  output logic                                   OUT_CACHE_we,
  output logic [LMC_SRAM_AW-1:0]                 OUT_CACHE_addr,
  output logic [LMC_DATA_W-1:0]                  OUT_CACHE_data,
  input  logic [LMC_DATA_W-1:0]                  IN_CACHE_data,
  output logic                                   OUT_EXT_cmdValid,
  input  logic                                   IN_EXT_cmdReady,
  output logic                                   OUT_EXT_write,
  output logic [LMC_EXT_AW-1:0]                  OUT_EXT_addr,
  output logic                                   OUT_EXT_wValid,
  output logic [LMC_DATA_W-1:0]                  OUT_EXT_wData,
  input  logic                                   IN_EXT_wReady,
  input  logic                                   IN_EXT_rValid,
  input  logic [LMC_DATA_W-1:0]                  IN_EXT_rData,
  output LMCState_t                              OUT_dbgState
);

  localparam logic [LMC_SRAM_AW-1:0] LINE_CNT = LMC_SRAM_AW'(LINE_WORDS);
  localparam logic [LMC_SRAM_AW-1:0] LAST_IDX = LMC_SRAM_AW'(LINE_WORDS - 1);

  LMCState_t              state;
  LMCReq_t                req;
  logic [LMC_SRAM_AW-1:0] rd_cnt;      // SRAM reads issued in the current evict
  logic                   rd_pending;  // read strobe last cycle: IN_CACHE_data valid now

  logic                   grant_valid;
  logic [ID_W-1:0]        grant_id;
  logic [NUM_CACHES-1:0]  ce_rot;
  int                     win;

  logic                   fifo_push;
  logic                   fifo_pop;
  logic                   fifo_empty;
  logic                   fifo_full;
  logic [LMC_DATA_W-1:0]  fifo_head;
  logic [2:0]             occupancy;
  logic                   issue_rd;

  // ---------------------------------------------------------------- arbiter
  // Requests are rotated so that bit 0 of ce_rot is the highest-priority
  // requester; the winner index is rotated back afterwards.
`ifdef LMC_RR_ARB_EN
  logic [ID_W-1:0]         rr_ptr;
  logic [2*NUM_CACHES-1:0] ce_dbl;

  assign ce_dbl = {IN_ce, IN_ce} >> rr_ptr;
  assign ce_rot = ce_dbl[NUM_CACHES-1:0];

  // Pointer names the index after the last winner; moves only on acceptance.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (state == IDLE && grant_valid) begin
      rr_ptr <= (grant_id == ID_W'(NUM_CACHES - 1)) ? '0 : grant_id + 1'b1;
    end
  end
`else
  assign ce_rot = IN_ce;
`endif

  always_comb begin
    grant_valid = 1'b0;
    grant_id    = '0;
    win         = 0;
    // Descending scan: the lowest rotated index assigns last and wins.
    for (int i = NUM_CACHES - 1; i >= 0; i--) begin
      if (ce_rot[i]) begin
`ifdef LMC_RR_ARB_EN
        win = int'(rr_ptr) + i;
        if (win >= NUM_CACHES) win = win - NUM_CACHES;
`else
        win = i;
`endif
        grant_valid = 1'b1;
        grant_id    = ID_W'(win);
      end
    end
  end

  // ------------------------------------------------------------ evict path
  // Words in flight: buffered in the FIFO, strobe on the SRAM port now, or
  // data arriving on IN_CACHE_data now. A new read is issued only while this
  // stays below 2, so the FIFO can never overflow.
  assign occupancy = {1'b0, fifo_full, ~fifo_full & ~fifo_empty}
                   + {2'b00, OUT_CACHE_ce & ~OUT_CACHE_we}
                   + {2'b00, rd_pending};
  assign issue_rd  = (state == XFER_WR) && (rd_cnt != LINE_CNT) && (occupancy < 3'd2);
  assign fifo_push = rd_pending;
  assign fifo_pop  = OUT_EXT_wValid & IN_EXT_wReady;

  lmc_skid_fifo u_skid_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (IN_CACHE_data),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full)
  );

  assign OUT_EXT_wValid = ~fifo_empty;
  assign OUT_EXT_wData  = fifo_head;

  // Command payload comes straight from the latched request, so it is
  // inherently stable for the whole CMD state.
  assign OUT_EXT_addr  = req.extAddr;
  assign OUT_EXT_write = req.we;
  assign OUT_cacheID   = ID_W'(req.id);
  assign OUT_dbgState  = state;

  // ------------------------------------------------------------------- FSM
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      req              <= '0;
      rd_cnt           <= '0;
      rd_pending       <= 1'b0;
      OUT_busy         <= 1'b0;
      OUT_progress     <= '0;
      OUT_CACHE_ce     <= 1'b0;
      OUT_CACHE_we     <= 1'b0;
      OUT_CACHE_addr   <= '0;
      OUT_CACHE_data   <= '0;
      OUT_EXT_cmdValid <= 1'b0;
    end else begin
      OUT_CACHE_ce <= 1'b0;
      OUT_CACHE_we <= 1'b0;
      rd_pending   <= OUT_CACHE_ce & ~OUT_CACHE_we;

      case (state)
        IDLE: begin
          if (grant_valid) begin
            req.we           <= IN_we[grant_id];
            req.sramAddr     <= IN_sramAddr[grant_id];
            req.extAddr      <= IN_extAddr[grant_id];
            req.id           <= LMC_ID_MAX_W'(grant_id);
            OUT_progress     <= '0;
            OUT_busy         <= 1'b1;
            OUT_EXT_cmdValid <= 1'b1;
            rd_cnt           <= '0;
            state            <= CMD;
          end
        end

        CMD: begin
          // rValid beats seen here precede command acceptance and are ignored.
          if (IN_EXT_cmdReady) begin
            OUT_EXT_cmdValid <= 1'b0;
            state            <= req.we ? XFER_WR : XFER_RD;
          end
        end

        XFER_RD: begin
          // progress == LINE_CNT means the final write strobe is on the port
          // this cycle; leave so busy drops on the following cycle.
          if (OUT_progress == LINE_CNT) begin
            OUT_busy <= 1'b0;
            state    <= IDLE;
          end else if (IN_EXT_rValid) begin
            OUT_CACHE_ce   <= 1'b1;
            OUT_CACHE_we   <= 1'b1;
            OUT_CACHE_addr <= lmc_word_addr(req.sramAddr, OUT_progress);
            OUT_CACHE_data <= IN_EXT_rData;
            OUT_progress   <= OUT_progress + 1'b1;
          end
        end

        XFER_WR: begin
          if (issue_rd) begin
            OUT_CACHE_ce   <= 1'b1;
            OUT_CACHE_addr <= lmc_word_addr(req.sramAddr, rd_cnt);
            rd_cnt         <= rd_cnt + 1'b1;
          end
          if (fifo_pop) begin
            OUT_progress <= OUT_progress + 1'b1;
            if (OUT_progress == LAST_IDX) begin
              OUT_busy <= 1'b0;
              state    <= IDLE;
            end
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
